// File: rtl/cache_pkg.sv
// Shared types for the direct-mapped write-back cache controller: request
// opcodes, controller states and the tag-width derivation.
package cache_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_FLUSH = 2'd2
  } req_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WB_REQ,
    ST_WB_WAIT,
    ST_FILL_REQ,
    ST_FILL_WAIT,
    ST_INSTALL
  } ctrl_state_e;

  // Byte address = {tag, set, word, byte-in-word(2)}.
  function automatic int tag_size(input int addr_width, input int set_size,
                                  input int word_sel_size);
    return addr_width - set_size - word_sel_size - 2;
  endfunction

endpackage

// File: rtl/cache_controller.sv
// Sequencing FSM for a direct-mapped write-back cache: lookup, word-by-word
// write-back and refill, metadata strobes and line-array steering.
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int SET_SIZE      = 2,
  parameter int WORD_SEL_SIZE = 2,
  parameter int READ_ONLY     = 0,
  localparam int TAG_SIZE     = tag_size(ADDR_WIDTH, SET_SIZE, WORD_SEL_SIZE)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [1:0]               req_op,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  output logic                     req_ready,
  output logic                     req_done,
  output logic [SET_SIZE-1:0]      meta_set,
  output logic [TAG_SIZE-1:0]      meta_tag,
  output logic                     meta_clear_valid,
  output logic                     meta_install,
  output logic                     meta_clear_dirty,
  output logic                     meta_set_dirty,
  input  logic                     meta_hit,
  input  logic                     meta_valid_dirty,
  input  logic [TAG_SIZE-1:0]      meta_victim_tag,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_write,
  output logic [ADDR_WIDTH-1:0]    mem_req_addr,
  input  logic                     mem_rsp_valid,
  output logic [WORD_SEL_SIZE-1:0] line_word_sel,
  output logic                     line_fill_we,
  output logic                     line_cpu_we
);

  localparam bit RO = (READ_ONLY != 0);

  ctrl_state_e               state_reg, state_next;
  logic [WORD_SEL_SIZE-1:0]  beat_reg, beat_next;
  logic [ADDR_WIDTH-3:0]     waddr_reg;
  req_op_e                   op_reg;

  logic                      accept;
  logic                      valid_dirty;
  logic                      last_beat;
  logic [WORD_SEL_SIZE-1:0]  word_idx;
  logic [SET_SIZE-1:0]       set_idx;
  logic [TAG_SIZE-1:0]       tag_idx;
  logic                      unused_addr_bits;

  assign accept           = !reset && (state_reg == ST_IDLE) && req_valid;
  assign valid_dirty      = meta_valid_dirty && !RO;
  assign last_beat        = &beat_reg;
  assign word_idx         = waddr_reg[WORD_SEL_SIZE-1:0];
  assign set_idx          = waddr_reg[WORD_SEL_SIZE +: SET_SIZE];
  assign tag_idx          = waddr_reg[ADDR_WIDTH-3 -: TAG_SIZE];
  assign unused_addr_bits = &{1'b0, req_addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      beat_reg  <= '0;
      waddr_reg <= '0;
      op_reg    <= OP_READ;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      if (accept) begin
        waddr_reg <= req_addr[ADDR_WIDTH-1:2];
        op_reg    <= req_op_e'(req_op);
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    beat_next        = beat_reg;
    req_ready        = 1'b0;
    req_done         = 1'b0;
    meta_set         = '0;
    meta_tag         = '0;
    meta_clear_valid = 1'b0;
    meta_install     = 1'b0;
    meta_clear_dirty = 1'b0;
    meta_set_dirty   = 1'b0;
    mem_req_valid    = 1'b0;
    mem_req_write    = 1'b0;
    mem_req_addr     = '0;
    line_word_sel    = '0;
    line_fill_we     = 1'b0;
    line_cpu_we      = 1'b0;
    // Outputs are forced low for the whole reset cycle, whatever the old state.
    if (!reset) begin
      meta_set = set_idx;
      meta_tag = tag_idx;
      case (state_reg)
        ST_IDLE: begin
          req_ready = 1'b1;
          if (req_valid) state_next = ST_LOOKUP;
        end
        ST_LOOKUP: begin
          beat_next = '0;
          if (op_reg == OP_FLUSH) begin
            if (valid_dirty) begin
              state_next = ST_WB_REQ;
            end else begin
              meta_clear_valid = 1'b1;
              req_done         = 1'b1;
              state_next       = ST_IDLE;
            end
          end else if (RO && op_reg == OP_WRITE) begin
            req_done   = 1'b1;
            state_next = ST_IDLE;
          end else if (meta_hit) begin
            if (op_reg == OP_WRITE) begin
              line_cpu_we    = 1'b1;
              line_word_sel  = word_idx;
              meta_set_dirty = 1'b1;
            end
            req_done   = 1'b1;
            state_next = ST_IDLE;
          end else if (valid_dirty) begin
            state_next = ST_WB_REQ;
          end else begin
            meta_clear_valid = 1'b1;
            state_next       = ST_FILL_REQ;
          end
        end
        ST_WB_REQ: begin
          mem_req_valid = 1'b1;
          mem_req_write = 1'b1;
          mem_req_addr  = {meta_victim_tag, set_idx, beat_reg, 2'b00};
          line_word_sel = beat_reg;
          if (mem_req_ready) state_next = ST_WB_WAIT;
        end
        ST_WB_WAIT: begin
          if (mem_rsp_valid) begin
            if (last_beat) begin
              // Victim gone: drop valid and dirty together, then refill or finish.
              meta_clear_dirty = !RO;
              meta_clear_valid = 1'b1;
              beat_next        = '0;
              if (op_reg == OP_FLUSH) begin
                req_done   = 1'b1;
                state_next = ST_IDLE;
              end else begin
                state_next = ST_FILL_REQ;
              end
            end else begin
              beat_next  = beat_reg + 1'b1;
              state_next = ST_WB_REQ;
            end
          end
        end
        ST_FILL_REQ: begin
          mem_req_valid = 1'b1;
          mem_req_addr  = {tag_idx, set_idx, beat_reg, 2'b00};
          if (mem_req_ready) state_next = ST_FILL_WAIT;
        end
        ST_FILL_WAIT: begin
          if (mem_rsp_valid) begin
            line_fill_we  = 1'b1;
            line_word_sel = beat_reg;
            beat_next     = beat_reg + 1'b1;
            state_next    = last_beat ? ST_INSTALL : ST_FILL_REQ;
          end
        end
        ST_INSTALL: begin
          // The dirty bit has no reset value, so a fresh line clears it here.
          meta_install     = 1'b1;
          meta_clear_dirty = !RO;
          state_next       = ST_LOOKUP;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(meta_clear_valid && meta_install))
        else $error("meta_clear_valid and meta_install asserted together");
      assert (!(meta_clear_dirty && meta_set_dirty))
        else $error("meta_clear_dirty and meta_set_dirty asserted together");
    end
  end

  generate
    if (RO) begin : g_ro_write_check
      always_ff @(posedge clk) begin
        if (accept) begin
          assert (req_op != OP_WRITE) else $error("WRITE issued to a read-only cache");
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: emulates the metadata store and a zero-wait
// memory, and checks each request against a transaction-level cache model.
module tb_cache_controller;
  import cache_pkg::*;

  localparam int AW    = 32;
  localparam int TS    = 26;
  localparam int NSETS = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [1:0]    req_op = 2'd0;
  logic [AW-1:0] req_addr = '0;
  logic          req_ready, req_done;
  logic [1:0]    meta_set;
  logic [TS-1:0] meta_tag;
  logic          meta_clear_valid, meta_install, meta_clear_dirty, meta_set_dirty;
  logic          meta_hit, meta_valid_dirty;
  logic [TS-1:0] meta_victim_tag;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b1;
  logic          mem_req_write;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid = 1'b0;
  logic [1:0]    line_word_sel;
  logic          line_fill_we, line_cpu_we;
  logic [71:0]   all_out;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_ready(req_ready), .req_done(req_done),
    .meta_set(meta_set), .meta_tag(meta_tag),
    .meta_clear_valid(meta_clear_valid), .meta_install(meta_install),
    .meta_clear_dirty(meta_clear_dirty), .meta_set_dirty(meta_set_dirty),
    .meta_hit(meta_hit), .meta_valid_dirty(meta_valid_dirty),
    .meta_victim_tag(meta_victim_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .line_word_sel(line_word_sel), .line_fill_we(line_fill_we),
    .line_cpu_we(line_cpu_we)
  );

  assign all_out = {req_ready, req_done, meta_set, meta_tag, meta_clear_valid, meta_install,
                    meta_clear_dirty, meta_set_dirty, mem_req_valid, mem_req_write,
                    mem_req_addr, line_word_sel, line_fill_we, line_cpu_we};

  // Emulated metadata store, updated only by the controller's strobes.
  logic          st_valid [NSETS];
  logic          st_dirty [NSETS];
  logic [TS-1:0] st_tag   [NSETS];
  assign meta_hit         = st_valid[meta_set] && (st_tag[meta_set] == meta_tag);
  assign meta_valid_dirty = st_valid[meta_set] && st_dirty[meta_set];
  assign meta_victim_tag  = st_tag[meta_set];

  // Reference cache state.
  bit            m_valid [NSETS];
  bit            m_dirty [NSETS];
  logic [TS-1:0] m_tag   [NSETS];
  logic [32:0]   exp_ops[$];
  int            exp_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [32:0] obs_ops[$];
  int done_cyc, cv_cyc, inst_cyc, sd_cyc, both_cyc, cpu_cyc, viol, fill_n, stall_left;
  logic [1:0] cpu_sel;

  task automatic model_txn(input logic [1:0] op, input logic [31:0] a, input int k);
    int s;
    logic [TS-1:0] t;
    bit hit, dirty;
    s = int'(a[5:4]);
    t = a[31:6];
    hit = m_valid[s] && (m_tag[s] == t);
    dirty = m_valid[s] && m_dirty[s];
    exp_ops.delete();
    if (op == OP_FLUSH) begin
      if (dirty)
        for (int b = 0; b < 4; b++) exp_ops.push_back({1'b1, m_tag[s], a[5:4], 2'(b), 2'b00});
      exp_done = dirty ? 9 : 1;
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end else if (hit) begin
      exp_done = 1;
      if (op == OP_WRITE) m_dirty[s] = 1'b1;
    end else begin
      if (dirty)
        for (int b = 0; b < 4; b++) exp_ops.push_back({1'b1, m_tag[s], a[5:4], 2'(b), 2'b00});
      for (int b = 0; b < 4; b++) exp_ops.push_back({1'b0, t, a[5:4], 2'(b), 2'b00});
      exp_done = (dirty ? 19 : 11) + k;
      m_valid[s] = 1'b1;
      m_tag[s] = t;
      m_dirty[s] = (op == OP_WRITE);
    end
  endtask

  // Drives one request from an IDLE cycle and records what the controller does.
  task automatic run_txn(input logic [1:0] op, input logic [31:0] a, input int k,
                         input bit noise, input int abort_fills);
    bit hs, fin, prev_stalled, prev_wr;
    bit u_cv, u_in, u_cd, u_sd;
    logic [1:0] u_set;
    logic [TS-1:0] u_tag;
    logic [31:0] prev_addr;
    int cyc;
    obs_ops.delete();
    done_cyc = -1; cv_cyc = -1; inst_cyc = -1; sd_cyc = -1; both_cyc = -1; cpu_cyc = -1;
    cpu_sel = 2'd0; viol = 0; fill_n = 0; stall_left = k;
    prev_stalled = 1'b0; prev_wr = 1'b0; prev_addr = '0; fin = 1'b0; cyc = 0;
    req_valid = 1'b1; req_op = op; req_addr = a; mem_req_ready = 1'b1;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      if (cyc == 0 && req_ready !== 1'b1) viol++;
      if (prev_stalled && (mem_req_valid !== 1'b1 || mem_req_addr !== prev_addr ||
                           mem_req_write !== prev_wr)) viol++;
      prev_stalled = mem_req_valid && !mem_req_ready;
      prev_addr = mem_req_addr;
      prev_wr = mem_req_write;
      if (meta_clear_valid && meta_install) viol++;
      if (meta_clear_dirty && meta_set_dirty) viol++;
      hs = mem_req_valid && mem_req_ready;
      if (hs) obs_ops.push_back({mem_req_write, mem_req_addr});
      if (mem_req_valid && !mem_req_write && !mem_req_ready && stall_left > 0) stall_left--;
      if (meta_clear_valid && cv_cyc < 0) cv_cyc = cyc;
      if (meta_install) inst_cyc = cyc;
      if (meta_set_dirty) sd_cyc = cyc;
      if (meta_clear_valid && meta_clear_dirty) both_cyc = cyc;
      if (line_fill_we) begin
        if (line_word_sel !== 2'(fill_n)) viol++;
        fill_n++;
      end
      if (line_cpu_we) begin
        cpu_cyc = cyc;
        cpu_sel = line_word_sel;
      end
      if (req_done) begin
        done_cyc = cyc;
        fin = 1'b1;
      end
      u_set = meta_set; u_tag = meta_tag;
      u_cv = meta_clear_valid; u_in = meta_install; u_cd = meta_clear_dirty; u_sd = meta_set_dirty;
      if (abort_fills > 0 && fill_n >= abort_fills) fin = 1'b1;
      @(posedge clk); #1;
      if (u_cv) st_valid[u_set] = 1'b0;
      if (u_in) begin
        st_valid[u_set] = 1'b1;
        st_tag[u_set] = u_tag;
      end
      if (u_cd) st_dirty[u_set] = 1'b0;
      if (u_sd) st_dirty[u_set] = 1'b1;
      mem_rsp_valid = hs || (noise && mem_req_valid && ($urandom_range(0, 1) == 1));
      req_valid = fin ? 1'b0 : 1'($urandom_range(0, 1));
      if (!fin) begin
        req_op = 2'($urandom_range(0, 3));
        req_addr = $urandom;
      end
      mem_req_ready = !(stall_left > 0 && mem_req_valid && !mem_req_write);
      cyc++;
    end
    $display("txn op=%0d addr=%h done_cycle=%0d mem_ops=%0d", op, a, done_cyc, obs_ops.size());
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (all_out !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_cmp++;
    if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mem_idle: got %b want 0", mem_req_valid); end
    @(posedge clk); #1;
    $display("txn reset released, req_ready=%0b", req_ready);
  endtask

  task automatic test_clean_miss;
    logic [32:0] e;
    model_txn(OP_READ, 32'h104, 0);
    run_txn(OP_READ, 32'h104, 0, 1'b0, 0);
    n_cmp++; if (cv_cyc !== 1) begin n_bad++; $display("FAIL clean_miss_clear_valid: cycle %0d want 1", cv_cyc); end
    n_cmp++; if (inst_cyc !== 10) begin n_bad++; $display("FAIL clean_miss_install: cycle %0d want 10", inst_cyc); end
    n_cmp++; if (done_cyc !== 11) begin n_bad++; $display("FAIL clean_miss_done: cycle %0d want 11", done_cyc); end
    n_cmp++; if (obs_ops.size() !== 4) begin n_bad++; $display("FAIL clean_miss_beats: got %0d want 4", obs_ops.size()); end
    for (int i = 0; i < 4 && i < obs_ops.size(); i++) begin
      e = {1'b0, 32'h100 + 32'(4 * i)};
      n_cmp++; if (obs_ops[i] !== e) begin n_bad++; $display("FAIL clean_miss_beat%0d: got %h want %h", i, obs_ops[i], e); end
    end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL clean_miss_protocol: %0d violations want 0", viol); end
  endtask

  task automatic test_hit;
    model_txn(OP_READ, 32'h104, 0);
    run_txn(OP_READ, 32'h104, 0, 1'b0, 0);
    n_cmp++; if (done_cyc !== 1) begin n_bad++; $display("FAIL read_hit_done: cycle %0d want 1", done_cyc); end
    n_cmp++; if (obs_ops.size() !== 0) begin n_bad++; $display("FAIL read_hit_mem: got %0d ops want 0", obs_ops.size()); end
  endtask

  task automatic test_write_hit;
    model_txn(OP_WRITE, 32'h108, 0);
    run_txn(OP_WRITE, 32'h108, 0, 1'b0, 0);
    n_cmp++; if (cpu_cyc !== 1) begin n_bad++; $display("FAIL write_hit_cpu_we: cycle %0d want 1", cpu_cyc); end
    n_cmp++; if (cpu_sel !== 2'd2) begin n_bad++; $display("FAIL write_hit_word_sel: got %0d want 2", cpu_sel); end
    n_cmp++; if (sd_cyc !== 1) begin n_bad++; $display("FAIL write_hit_set_dirty: cycle %0d want 1", sd_cyc); end
    n_cmp++; if (done_cyc !== 1) begin n_bad++; $display("FAIL write_hit_done: cycle %0d want 1", done_cyc); end
  endtask

  task automatic test_dirty_miss;
    logic [32:0] e;
    model_txn(OP_READ, 32'h148, 0);
    run_txn(OP_READ, 32'h148, 0, 1'b0, 0);
    n_cmp++; if (obs_ops.size() !== 8) begin n_bad++; $display("FAIL dirty_miss_beats: got %0d want 8", obs_ops.size()); end
    for (int i = 0; i < 8 && i < obs_ops.size(); i++) begin
      e = (i < 4) ? {1'b1, 32'h100 + 32'(4 * i)} : {1'b0, 32'h140 + 32'(4 * (i - 4))};
      n_cmp++; if (obs_ops[i] !== e) begin n_bad++; $display("FAIL dirty_miss_beat%0d: got %h want %h", i, obs_ops[i], e); end
    end
    n_cmp++; if (both_cyc !== 9) begin n_bad++; $display("FAIL dirty_miss_wb_exit: cycle %0d want 9", both_cyc); end
    n_cmp++; if (done_cyc !== 19) begin n_bad++; $display("FAIL dirty_miss_done: cycle %0d want 19", done_cyc); end
  endtask

  task automatic test_flush;
    logic [32:0] e;
    model_txn(OP_WRITE, 32'h140, 0);
    run_txn(OP_WRITE, 32'h140, 0, 1'b0, 0);
    model_txn(OP_FLUSH, 32'h140, 0);
    run_txn(OP_FLUSH, 32'h140, 0, 1'b0, 0);
    n_cmp++; if (obs_ops.size() !== 4) begin n_bad++; $display("FAIL flush_dirty_beats: got %0d want 4", obs_ops.size()); end
    for (int i = 0; i < 4 && i < obs_ops.size(); i++) begin
      e = {1'b1, 32'h140 + 32'(4 * i)};
      n_cmp++; if (obs_ops[i] !== e) begin n_bad++; $display("FAIL flush_dirty_beat%0d: got %h want %h", i, obs_ops[i], e); end
    end
    n_cmp++; if (done_cyc !== 9) begin n_bad++; $display("FAIL flush_dirty_done: cycle %0d want 9", done_cyc); end
    n_cmp++; if (st_valid[0] !== m_valid[0]) begin n_bad++; $display("FAIL flush_dirty_valid: got %b want %b", st_valid[0], m_valid[0]); end
    model_txn(OP_FLUSH, 32'h140, 0);
    run_txn(OP_FLUSH, 32'h140, 0, 1'b0, 0);
    n_cmp++; if (cv_cyc !== 1) begin n_bad++; $display("FAIL flush_clean_clear_valid: cycle %0d want 1", cv_cyc); end
    n_cmp++; if (done_cyc !== 1) begin n_bad++; $display("FAIL flush_clean_done: cycle %0d want 1", done_cyc); end
    n_cmp++; if (obs_ops.size() !== 0) begin n_bad++; $display("FAIL flush_clean_mem: got %0d ops want 0", obs_ops.size()); end
  endtask

  task automatic test_fill_stall;
    logic [32:0] e;
    model_txn(OP_READ, 32'h210, 3);
    run_txn(OP_READ, 32'h210, 3, 1'b0, 0);
    n_cmp++; if (done_cyc !== 14) begin n_bad++; $display("FAIL stall_done: cycle %0d want 14", done_cyc); end
    n_cmp++; if (obs_ops.size() !== 4) begin n_bad++; $display("FAIL stall_beats: got %0d want 4", obs_ops.size()); end
    for (int i = 0; i < 4 && i < obs_ops.size(); i++) begin
      e = {1'b0, 32'h210 + 32'(4 * i)};
      n_cmp++; if (obs_ops[i] !== e) begin n_bad++; $display("FAIL stall_beat%0d: got %h want %h", i, obs_ops[i], e); end
    end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL stall_protocol: %0d violations want 0", viol); end
  endtask

  task automatic test_random;
    logic [1:0] op;
    logic [31:0] a;
    int k, s;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 2));
      a = {26'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
      k = $urandom_range(0, 2);
      s = int'(a[5:4]);
      model_txn(op, a, k);
      run_txn(op, a, k, 1'b1, 0);
      n_cmp++; if (done_cyc !== exp_done) begin n_bad++; $display("FAIL rand%0d_done: cycle %0d want %0d", n, done_cyc, exp_done); end
      n_cmp++; if (obs_ops.size() !== exp_ops.size()) begin n_bad++; $display("FAIL rand%0d_nops: got %0d want %0d", n, obs_ops.size(), exp_ops.size()); end
      for (int i = 0; i < exp_ops.size() && i < obs_ops.size(); i++) begin
        n_cmp++; if (obs_ops[i] !== exp_ops[i]) begin n_bad++; $display("FAIL rand%0d_op%0d: got %h want %h", n, i, obs_ops[i], exp_ops[i]); end
      end
      if (op == OP_WRITE) begin
        n_cmp++; if (cpu_cyc !== exp_done || cpu_sel !== a[3:2]) begin
          n_bad++; $display("FAIL rand%0d_cpu_we: cycle %0d sel %0d want cycle %0d sel %0d", n, cpu_cyc, cpu_sel, exp_done, a[3:2]);
        end
      end
      n_cmp++; if (st_valid[s] !== m_valid[s]) begin n_bad++; $display("FAIL rand%0d_valid: got %b want %b", n, st_valid[s], m_valid[s]); end
      if (m_valid[s]) begin
        n_cmp++; if (st_tag[s] !== m_tag[s]) begin n_bad++; $display("FAIL rand%0d_tag: got %h want %h", n, st_tag[s], m_tag[s]); end
        n_cmp++; if (st_dirty[s] !== m_dirty[s]) begin n_bad++; $display("FAIL rand%0d_dirty: got %b want %b", n, st_dirty[s], m_dirty[s]); end
      end
      n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL rand%0d_protocol: %0d violations want 0", n, viol); end
    end
  endtask

  task automatic test_reset_mid_fill;
    // Set 2 is clean, so the request clears its valid bit and starts filling.
    m_valid[2] = 1'b0;
    run_txn(OP_READ, 32'h320, 0, 1'b0, 2);
    reset = 1'b1;
    req_valid = 1'b0;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL midfill_reset_outputs: got %h want 0", all_out); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL midfill_ready: got %b want 1", req_ready); end
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL midfill_mem_idle: got %b want 0", mem_req_valid); end
    n_cmp++; if (st_valid[2] !== m_valid[2]) begin n_bad++; $display("FAIL midfill_valid: got %b want %b", st_valid[2], m_valid[2]); end
    @(posedge clk); #1;
    model_txn(OP_READ, 32'h104, 0);
    run_txn(OP_READ, 32'h104, 0, 1'b0, 0);
    n_cmp++; if (done_cyc !== exp_done) begin n_bad++; $display("FAIL after_reset_done: cycle %0d want %0d", done_cyc, exp_done); end
  endtask

  initial begin
    for (int i = 0; i < NSETS; i++) begin
      st_valid[i] = 1'b0;
      st_dirty[i] = 1'($urandom_range(0, 1));
      st_tag[i] = 26'($urandom);
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i] = '0;
    end
    test_reset();
    test_clean_miss();
    test_hit();
    test_write_hit();
    test_dirty_miss();
    test_flush();
    test_fill_stall();
    test_random();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing FSM for one direct-mapped, write-back cache. It accepts single-word CPU requests, drives the tag/valid/dirty metadata store via its set/tag and bit-update strobes, and evaluates hit and dirty status. Misses run a word-by-word write-back/refill against the memory port, and the controller steers the line data array through word-select and write-enable strobes. It holds no data storage and sits between the CPU port, the metadata store, the line data array and the next-level memory.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `SET_SIZE`, 2, set index bits (2^SET_SIZE sets)
- `WORD_SEL_SIZE`, 2, word-in-line bits (4 words/line)
- `READ_ONLY`, 0, 1 = no dirty tracking, no write-back
- Derived: `TAG_SIZE = ADDR_WIDTH - SET_SIZE - WORD_SEL_SIZE - 2`
- `clk` in 1 — clock
- `reset` in 1 — synchronous, active-high
- `req_valid` in 1; `req_op` in 2 (0 READ, 1 WRITE, 2 FLUSH); `req_addr` in ADDR_WIDTH
- `req_ready` out 1 — request accepted on `req_valid & req_ready`
- `req_done` out 1 — one-cycle completion pulse
- `meta_set` out SET_SIZE; `meta_tag` out TAG_SIZE — from latched address
- `meta_clear_valid`, `meta_install`, `meta_clear_dirty`, `meta_set_dirty` out 1 each — metadata strobes
- `meta_hit` in 1; `meta_valid_dirty` in 1; `meta_victim_tag` in TAG_SIZE
- `mem_req_valid` out 1; `mem_req_ready` in 1; `mem_req_write` out 1; `mem_req_addr` out ADDR_WIDTH (word-aligned)
- `mem_rsp_valid` in 1 — read data beat or write ack
- `line_word_sel` out WORD_SEL_SIZE; `line_fill_we` out 1; `line_cpu_we` out 1

## Operation
- States: IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, INSTALL.
- IDLE: `req_ready`=1. On accept, latch address and op, then go to LOOKUP.
- LOOKUP, READ hit: `req_done`, then IDLE.
- LOOKUP, WRITE hit: `line_cpu_we`, `line_word_sel` set to the address word, `meta_set_dirty`, `req_done`, then IDLE.
- LOOKUP, miss with `meta_valid_dirty`: beat counter to 0, then WB_REQ.
- LOOKUP, miss clean: `meta_clear_valid`, counter to 0, then FILL_REQ.
- LOOKUP, FLUSH: if `meta_valid_dirty`, go to WB_REQ. Otherwise assert `meta_clear_valid` and `req_done`, then IDLE.
- WB_REQ: `mem_req_valid`, `mem_req_write`=1.
  - `mem_req_addr = {meta_victim_tag, set, beat, 2'b00}`; `line_word_sel`=beat.
  - On `mem_req_ready`, go to WB_WAIT.
- WB_WAIT: on `mem_rsp_valid`, if beat==last go to the write-back exit, else beat+1 and back to WB_REQ.
  - Write-back exit: assert `meta_clear_dirty` and `meta_clear_valid` in the same cycle.
  - After that, FLUSH takes `req_done` and IDLE; all other ops go to FILL_REQ with beat 0.
- FILL_REQ: `mem_req_valid`, `mem_req_write`=0, address `{tag, set, beat, 2'b00}`. On ready, go to FILL_WAIT.
- FILL_WAIT: on `mem_rsp_valid`, assert `line_fill_we` with `line_word_sel`=beat.
  - If last beat, go to INSTALL; else beat+1 and back to FILL_REQ.
- INSTALL: `meta_install` and `meta_clear_dirty`; the dirty bit is not reset-initialised, so it is cleared on install. Then LOOKUP, which now hits and completes the op.
- Strobe exclusivity:
  - `meta_clear_valid` and `meta_install` are never asserted together.
  - `meta_clear_dirty` and `meta_set_dirty` are never asserted together.
- READ_ONLY=1: `meta_valid_dirty` is treated as 0, and dirty strobes stay 0.
  - WRITE completes with `req_done` and changes no state; an assertion flags it.
- All outputs not named in a state are 0.

## Timing
- Reset: state IDLE, counter 0, and every output 0, including `req_ready` during the reset cycle. `req_ready`=1 from the first post-reset cycle.
- Reset mid-miss abandons the transaction; the memory side is reset together with the controller.
- Hit latency: accept at cycle 0, `req_done` at cycle 1.
- Each beat costs at least 2 cycles: one in REQ (ready) and at least one in WAIT. `mem_rsp_valid` is ignored outside the WAIT states.
- Clean read miss with zero-wait memory: `req_done` at cycle 11.
  - Cycle 1 LOOKUP, cycles 2–9 fill, cycle 10 INSTALL, cycle 11 LOOKUP.
- Dirty miss adds 8 cycles, giving `req_done` at cycle 19.
- `mem_req_valid` holds with stable address until `mem_req_ready`.
- `req_valid` is ignored outside IDLE.

## Structure
- Shared package `cache_pkg`:
  - `req_op_e` enum (READ/WRITE/FLUSH)
  - `ctrl_state_e` enum
  - TAG_SIZE derivation function
- Single module; the beat counter is inline. No sub-module.

## Test plan
All cases use defaults (TAG_SIZE=26) and zero-wait memory.

- Reset, then READ 0x0000_0104 (set 0, word 1, tag 0x4) → clean-miss path.
  - `meta_clear_valid` at cycle 1.
  - Four read beats to 0x100, 0x104, 0x108, 0x10C.
  - `meta_install` at cycle 10, `req_done` at cycle 11.
- Repeat READ 0x104 with `meta_hit`=1 → `req_done` at cycle 1, no `mem_req_valid`.
- WRITE 0x108 hit → at cycle 1: `line_cpu_we`=1, `line_word_sel`=2, `meta_set_dirty`=1, `req_done`=1.
- READ 0x0000_0148 (set 0, tag 0x5) with `meta_valid_dirty`=1, victim tag 0x4:
  - Write beats to 0x100–0x10C, then `meta_clear_dirty` and `meta_clear_valid` together.
  - Then fills 0x140–0x14C; `req_done` at cycle 19.
- FLUSH set 0, dirty → four write-backs, then `req_done`, with no fill requests.
- FLUSH set 0, clean → `meta_clear_valid` and `req_done` at cycle 1.
- `mem_req_ready` held low 3 cycles during FILL_REQ → address stable and no beat skipped.
- Reset asserted mid-fill → next cycle all outputs 0; then IDLE with `req_ready`=1.
